// File: rtl/dptr_pkg.sv
// Shared definitions for the instruction-memory loader.
//   ld_state_e     : loader FSM states
//   BYTES_PER_WORD : bytes per instruction word
//   DEF_MEM_BYTES  : default instruction memory size, shared with the memory
package dptr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_MEM_BYTES  = 1024;

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one 32-bit word and presents it as four big-endian bytes.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : capture word_i and restart at byte 0
//   advance_i    : step to the next byte
//   word_i       : word to serialize
//   byte_o       : current byte (index 0 = bits 31:24)
//   idx_o        : current byte index
//   last_o       : current byte is index 3
module imem_byte_serializer
    import dptr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [31:0] word_i,
    output logic [7:0]  byte_o,
    output logic [1:0]  idx_o,
    output logic        last_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 2'd0;
        end else if (advance_i) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= 32'd0;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    byte_o = word_q[31:24];
            2'd1:    byte_o = word_q[23:16];
            2'd2:    byte_o = word_q[15:8];
            default: byte_o = word_q[7:0];
        endcase
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction memory program loader: takes 32-bit words over a valid/ready
// stream and writes each as four bytes, MSB at the lowest address.
//   clk_i, rst_i       : clock, async active-high reset
//   start_i, abort_i   : begin / cancel a load
//   base_addr_i        : byte address of first word (must be word aligned)
//   word_count_i       : words to load
//   word_i/_valid_i    : word stream in, word_ready_o back-pressure
//   mem_we_o/addr/data : byte write port to instruction memory
//   busy_o, done_o     : load active / one-cycle end-of-start pulse
//   error_o            : sticky rejection/abort flag
//   words_written_o    : words fully written in current load
//   checksum_o         : mod-2^32 sum of accepted words (IMEM_LOADER_CHECKSUM_EN)
//
// state  | meaning
// IDLE   | waiting for start_i, validates request
// ACCEPT | word_ready_o high, waiting for a word
// WRITE  | emitting the four bytes of the held word
// DONE   | one-cycle done_o pulse
module imem_loader
    import dptr_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic [31:0]      word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [7:0]       mem_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_written_o
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum_o
`endif
);

    ld_state_e        state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] words_inc;
    logic [33:0]      end_addr;
    logic             req_bad;
    logic             ser_load, ser_adv, ser_last;
    logic [7:0]       ser_byte;
    logic [1:0]       ser_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      csum_q, csum_d;
`endif

    // 34-bit end address so a large base plus count cannot wrap past the check.
    assign end_addr  = {2'b00, base_addr_i} + {{(32-CNT_W){1'b0}}, word_count_i, 2'b00};
    assign req_bad   = (base_addr_i[1:0] != 2'b00) || (end_addr > 34'(MEM_BYTES));
    assign words_inc = words_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        count_d    = count_q;
        words_d    = words_q;
        error_d    = error_q;
        ser_load   = 1'b0;
        ser_adv    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                // abort in IDLE overrides start and leaves error_o alone
                if (start_i && !abort_i) begin
                    state_d = DONE;
                    if (req_bad) begin
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        words_d    = '0;
                        cur_addr_d = base_addr_i;
                        count_d    = word_count_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d     = 32'd0;
`endif
                        if (word_count_i != '0) state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (word_valid_i) begin
                    ser_load = 1'b1;
                    state_d  = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q + word_i;
`endif
                end
            end
            WRITE: begin
                ser_adv = 1'b1;
                if (ser_last) begin
                    cur_addr_d = cur_addr_q + 32'(BYTES_PER_WORD);
                    words_d    = words_inc;
                    state_d    = (words_inc == count_q) ? DONE : ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i && state_q != IDLE) begin
            state_d    = IDLE;
            error_d    = 1'b1;
            words_d    = words_q;
            cur_addr_d = cur_addr_q;
            ser_load   = 1'b0;
            ser_adv    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = csum_q;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_addr_q <= 32'd0;
            count_q    <= '0;
            words_q    <= '0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            count_q    <= count_d;
            words_q    <= words_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    imem_byte_serializer u_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (ser_load),
        .advance_i (ser_adv),
        .word_i    (word_i),
        .byte_o    (ser_byte),
        .idx_o     (ser_idx),
        .last_o    (ser_last)
    );

    assign word_ready_o    = (state_q == ACCEPT);
    assign mem_we_o        = (state_q == WRITE);
    assign mem_addr_o      = mem_we_o ? (cur_addr_q + {30'd0, ser_idx}) : 32'd0;
    assign mem_data_o      = mem_we_o ? ser_byte : 8'd0;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign error_o         = error_q;
    assign words_written_o = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum_o      = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [31:0]      base_addr_i = 32'd0;
    logic [CNT_W-1:0] word_count_i = '0;
    logic [31:0]      word_i = 32'd0;
    logic             word_valid_i = 1'b0;
    logic             word_ready_o, mem_we_o, busy_o, done_o, error_o;
    logic [31:0]      mem_addr_o;
    logic [7:0]       mem_data_o;
    logic [CNT_W-1:0] words_written_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      checksum_o;
`endif

    imem_loader #(.MEM_BYTES(1024), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .base_addr_i     (base_addr_i),
        .word_count_i    (word_count_i),
        .word_i          (word_i),
        .word_valid_i    (word_valid_i),
        .word_ready_o    (word_ready_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .words_written_o (words_written_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum_o      (checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] stim_words[$];
    int          stim_gaps[$];
    logic [31:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          done_edge, done_pulses, ready_cycles;
    logic [31:0] cs_at_done;

    // Reference: word i lands at base+4i..base+4i+3, most significant byte first.
    function automatic void build_expect(input logic [31:0] base, input int nwords);
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < nwords; i++) begin
            w = stim_words[i];
            for (int j = 0; j < 4; j++) begin
                exp_addr.push_back(base + 32'(4 * i + j));
                exp_data.push_back(8'((w >> (24 - 8 * j)) & 32'hFF));
            end
        end
    endfunction

    function automatic logic [31:0] sum_words(input int nwords);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < nwords; i++) s = s + stim_words[i];
        return s;
    endfunction

    // Drives one start plus the word stream; stim_gaps[k] is the number of
    // ready cycles with valid low before word k. abort_after>=0 raises abort_i
    // once that many byte writes have been seen. Edge 1 is the start edge.
    task automatic run_load(input logic [31:0] base, input int count, input int abort_after);
        int  k = 0;
        int  gap;
        int  tail = 0;
        bit  hs = 0;
        bit  aborted = 0;
        got_addr.delete();
        got_data.delete();
        done_edge = -1;
        done_pulses = 0;
        ready_cycles = 0;
        cs_at_done = 32'd0;
        gap = (stim_gaps.size() > 0) ? stim_gaps[0] : 0;
        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        word_count_i = CNT_W'(count);
        word_valid_i = (k < stim_words.size()) && (gap == 0);
        word_i = (k < stim_words.size()) ? stim_words[k] : $urandom;
        for (int e = 1; e <= 600; e++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            abort_i = 1'b0;
            if (hs) begin
                k++;
                gap = (k < stim_gaps.size()) ? stim_gaps[k] : 0;
            end
            if (mem_we_o) begin
                got_addr.push_back(mem_addr_o);
                got_data.push_back(mem_data_o);
            end
            if (done_o) begin
                done_pulses++;
                if (done_edge < 0) done_edge = e;
`ifdef IMEM_LOADER_CHECKSUM_EN
                cs_at_done = checksum_o;
`endif
            end
            if (word_ready_o) ready_cycles++;
            word_valid_i = (k < stim_words.size()) && (gap == 0);
            word_i = word_valid_i ? stim_words[k] : $urandom;
            if (word_ready_o && gap > 0) gap--;
            hs = word_ready_o && word_valid_i;
            if (abort_after >= 0 && !aborted && got_addr.size() == abort_after) begin
                abort_i = 1'b1;
                aborted = 1;
            end
            if (!busy_o) begin
                tail++;
                if (tail >= 3) break;
            end
        end
        word_valid_i = 1'b0;
        if (tail < 3) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: busy_o still high after 600 cycles, required idle");
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({word_ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b required 00000", {word_ready_o, mem_we_o, busy_o, done_o, error_o});
        end
        vectors++;
        if (mem_addr_o !== 32'd0) begin
            miscompares++; $display("FAIL reset_addr got %h required 0", mem_addr_o);
        end
        vectors++;
        if (mem_data_o !== 8'd0) begin
            miscompares++; $display("FAIL reset_data got %h required 0", mem_data_o);
        end
        vectors++;
        if (words_written_o !== '0) begin
            miscompares++; $display("FAIL reset_words got %0d required 0", words_written_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_release_busy got %b required 0", busy_o);
        end
    endtask

    task automatic test_basic();
        stim_words = '{32'hDEADBEEF, 32'h00112233};
        stim_gaps = '{0, 0};
        build_expect(32'h10, 2);
        run_load(32'h10, 2, -1);
        vectors++;
        if (got_addr.size() !== 8) begin
            miscompares++; $display("FAIL basic_nwrites got %0d required 8", got_addr.size());
        end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            vectors++;
            if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                miscompares++;
                $display("FAIL basic_byte[%0d] got %h:%h required %h:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        vectors++;
        if (done_edge !== 11 || done_pulses !== 1) begin
            miscompares++; $display("FAIL basic_done got edge %0d pulses %0d required edge 11 pulses 1", done_edge, done_pulses);
        end
        vectors++;
        if (words_written_o !== 16'd2 || error_o !== 1'b0) begin
            miscompares++; $display("FAIL basic_status got words %0d err %b required 2/0", words_written_o, error_o);
        end
    endtask

    task automatic test_misaligned();
        stim_words = '{32'h12345678};
        stim_gaps = '{0};
        run_load(32'h2, 1, -1);
        vectors++;
        if (got_addr.size() !== 0 || ready_cycles !== 0) begin
            miscompares++; $display("FAIL misalign_nowrite got writes %0d ready %0d required 0/0", got_addr.size(), ready_cycles);
        end
        vectors++;
        if (done_edge !== 1 || done_pulses !== 1 || error_o !== 1'b1) begin
            miscompares++; $display("FAIL misalign_done got edge %0d pulses %0d err %b required 1/1/1", done_edge, done_pulses, error_o);
        end
        stim_words = '{32'hCAFEF00D};
        build_expect(32'h0, 1);
        run_load(32'h0, 1, -1);
        vectors++;
        if (error_o !== 1'b0 || got_addr.size() !== 4 || done_edge !== 6) begin
            miscompares++; $display("FAIL misalign_recover got err %b writes %0d edge %0d required 0/4/6", error_o, got_addr.size(), done_edge);
        end
    endtask

    task automatic test_range();
        stim_words = '{32'h01020304, 32'h05060708};
        stim_gaps = '{0, 0};
        run_load(32'h3FC, 2, -1);
        vectors++;
        if (got_addr.size() !== 0 || error_o !== 1'b1 || done_pulses !== 1) begin
            miscompares++; $display("FAIL range_reject got writes %0d err %b pulses %0d required 0/1/1", got_addr.size(), error_o, done_pulses);
        end
        build_expect(32'h3FC, 1);
        run_load(32'h3FC, 1, -1);
        vectors++;
        if (got_addr.size() !== 4 || error_o !== 1'b0) begin
            miscompares++; $display("FAIL range_edge got writes %0d err %b required 4/0", got_addr.size(), error_o);
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            vectors++;
            if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                miscompares++;
                $display("FAIL range_byte[%0d] got %h:%h required %h:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_gap();
        stim_words = '{32'hA1B2C3D4, 32'h55667788};
        stim_gaps = '{3, 0};
        build_expect(32'h80, 2);
        run_load(32'h80, 2, -1);
        vectors++;
        if (ready_cycles !== 5 || done_edge !== 14) begin
            miscompares++; $display("FAIL gap_timing got ready %0d edge %0d required 5/14", ready_cycles, done_edge);
        end
        vectors++;
        if (got_addr.size() !== 8) begin
            miscompares++; $display("FAIL gap_nwrites got %0d required 8", got_addr.size());
        end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            vectors++;
            if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                miscompares++;
                $display("FAIL gap_byte[%0d] got %h:%h required %h:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_abort();
        stim_words = '{$urandom, $urandom, $urandom};
        stim_gaps = '{0, 0, 0};
        build_expect(32'h200, 3);
        // sixth byte write is the second word's index 1
        run_load(32'h200, 3, 6);
        vectors++;
        if (got_addr.size() !== 6) begin
            miscompares++; $display("FAIL abort_nwrites got %0d required 6", got_addr.size());
        end
        for (int i = 0; i < 6 && i < got_addr.size(); i++) begin
            vectors++;
            if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                miscompares++;
                $display("FAIL abort_byte[%0d] got %h:%h required %h:%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        vectors++;
        if (done_pulses !== 0 || error_o !== 1'b1 || words_written_o !== 16'd1) begin
            miscompares++; $display("FAIL abort_status got pulses %0d err %b words %0d required 0/1/1", done_pulses, error_o, words_written_o);
        end
    endtask

    task automatic test_idle_abort_start();
        int hits = 0;
        logic err_before;
        err_before = error_o;
        vectors++;
        if (err_before !== 1'b1) begin
            miscompares++; $display("FAIL idle_abort_pre got err %b required 1", err_before);
        end
        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b1;
        base_addr_i = 32'h0; word_count_i = CNT_W'(1);
        word_valid_i = 1'b1; word_i = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            start_i = 1'b0; abort_i = 1'b0;
            if (busy_o || done_o || mem_we_o) hits++;
        end
        word_valid_i = 1'b0;
        vectors++;
        if (hits !== 0 || error_o !== 1'b1) begin
            miscompares++; $display("FAIL idle_abort_start got activity %0d err %b required 0/1", hits, error_o);
        end
    endtask

    task automatic test_zero_count();
        stim_words.delete();
        stim_gaps.delete();
        run_load(32'h100, 0, -1);
        vectors++;
        if (done_edge !== 1 || done_pulses !== 1 || got_addr.size() !== 0 || error_o !== 1'b0) begin
            miscompares++; $display("FAIL zero_count got edge %0d pulses %0d writes %0d err %b required 1/1/0/0", done_edge, done_pulses, got_addr.size(), error_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n, mode, gsum;
            logic [31:0] base;
            bit bad;
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 3);
            gsum = 0;
            stim_words.delete();
            stim_gaps.delete();
            for (int i = 0; i < n; i++) begin
                stim_words.push_back($urandom);
                stim_gaps.push_back($urandom_range(0, 2));
                gsum += stim_gaps[i];
            end
            if (mode == 0) base = 32'(4 * $urandom_range(0, 255 - n) + $urandom_range(1, 3));
            else if (mode == 1) base = 32'(4 * $urandom_range(257 - n, 256));
            else base = 32'(4 * $urandom_range(0, 256 - n));
            bad = (base % 4 != 0) || (base + 4 * n > 1024);
            build_expect(base, n);
            run_load(base, n, -1);
            if (bad) begin
                vectors++;
                if (got_addr.size() !== 0 || done_edge !== 1 || error_o !== 1'b1) begin
                    miscompares++; $display("FAIL rand_reject[%0d] base %h got writes %0d edge %0d err %b required 0/1/1", it, base, got_addr.size(), done_edge, error_o);
                end
            end else begin
                vectors++;
                if (got_addr.size() !== 4 * n) begin
                    miscompares++; $display("FAIL rand_nwrites[%0d] got %0d required %0d", it, got_addr.size(), 4 * n);
                end
                for (int i = 0; i < 4 * n && i < got_addr.size(); i++) begin
                    vectors++;
                    if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                        miscompares++;
                        $display("FAIL rand_byte[%0d][%0d] got %h:%h required %h:%h", it, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                    end
                end
                vectors++;
                if (done_edge !== 5 * n + 1 + gsum || done_pulses !== 1) begin
                    miscompares++; $display("FAIL rand_done[%0d] got edge %0d pulses %0d required %0d/1", it, done_edge, done_pulses, 5 * n + 1 + gsum);
                end
                vectors++;
                if (words_written_o !== CNT_W'(n) || error_o !== 1'b0) begin
                    miscompares++; $display("FAIL rand_status[%0d] got words %0d err %b required %0d/0", it, words_written_o, error_o, n);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                vectors++;
                if (cs_at_done !== sum_words(n)) begin
                    miscompares++; $display("FAIL rand_checksum[%0d] got %h required %h", it, cs_at_done, sum_words(n));
                end
`endif
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim_words = '{32'hFFFFFFFF, 32'h00000002};
        stim_gaps = '{0, 0};
        run_load(32'h40, 2, -1);
        vectors++;
        if (cs_at_done !== 32'h00000001) begin
            miscompares++; $display("FAIL checksum got %h required 00000001", cs_at_done);
        end
    endtask
`endif

    task automatic test_reset_midload();
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = 32'h40; word_count_i = CNT_W'(2);
        word_valid_i = 1'b1; word_i = 32'h89ABCDEF;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (mem_we_o !== 1'b1) begin
            miscompares++; $display("FAIL midload_writing got we %b required 1", mem_we_o);
        end
        #2 rst_i = 1'b1;
        #1;
        vectors++;
        if ({word_ready_o, mem_we_o, busy_o, done_o, error_o, mem_addr_o, mem_data_o, words_written_o} !== '0) begin
            miscompares++;
            $display("FAIL midload_reset got flags %b addr %h data %h words %0d required all 0", {word_ready_o, mem_we_o, busy_o, done_o, error_o}, mem_addr_o, mem_data_o, words_written_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        word_valid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || mem_we_o !== 1'b0) begin
            miscompares++; $display("FAIL midload_after got busy %b we %b required 0/0", busy_o, mem_we_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_range();
        test_gap();
        test_abort();
        test_idle_abort_start();
        test_zero_count();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and serializes each word into four byte writes, most significant byte at the lowest address, so the memory's word read returns the original word. It sits between the boot/debug host interface and the instruction memory's byte write port, and is active only before or between program runs.

## Interface
- MEM_BYTES, 1024: instruction memory size in bytes; writes beyond it are rejected
- CNT_W, 16: width of word count and progress counters
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  begin a load; sampled only in IDLE
- abort_i  input  1  cancel any load in progress
- base_addr_i  input  32  byte address of the first word; sampled with start_i
- word_count_i  input  CNT_W  number of words to load; sampled with start_i
- word_i  input  32  instruction word
- word_valid_i  input  1  word_i is valid
- word_ready_o  output  1  loader accepts word_i this cycle
- mem_we_o  output  1  byte write strobe to instruction memory
- mem_addr_o  output  32  byte write address
- mem_data_o  output  8  byte write data
- busy_o  output  1  load in progress (state not IDLE)
- done_o  output  1  one-cycle pulse at the end of every start, including rejected starts
- error_o  output  1  sticky; cleared by the next accepted start_i
- words_written_o  output  CNT_W  words fully written in the current load

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: word_ready_o=0, mem_we_o=0.
  - On start_i, validate the request:
    - base_addr_i%4 != 0, or base_addr_i + 4*word_count_i > MEM_BYTES: error_o<=1, go to DONE, no writes.
    - word_count_i==0: go to DONE, no writes, error_o<=0.
    - Otherwise: latch base/count, words_written_o<=0, error_o<=0, go to ACCEPT.
- ACCEPT: word_ready_o=1. On word_valid_i, latch word_i, byte index<=0, go to WRITE.
- WRITE: runs four cycles with idx 0..3.
  - mem_we_o=1, mem_addr_o=cur_addr+idx, mem_data_o=word[31-8*idx -: 8].
  - After idx 3: cur_addr+=4 and words_written_o+=1.
  - Then go to DONE if the new count equals word_count, else back to ACCEPT.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- abort_i in any non-IDLE state:
  - Next cycle: IDLE, mem_we_o=0, error_o=1, no done_o.
  - words_written_o holds its value.
  - A partially written word is left as-is in memory.
- abort_i and start_i together in IDLE: abort wins, start is ignored, error_o is unchanged.
- start_i outside IDLE is ignored.
- Address arithmetic is 32-bit. The range check uses a 34-bit sum so it never wraps.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from word_valid_i to word_ready_o.
- Reset values: state IDLE; word_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, busy_o=0, done_o=0, error_o=0, words_written_o=0.
- Throughput: 5 cycles per word (1 accept cycle + 4 write cycles) when word_valid_i is held high.
- Latency from start_i to first mem_we_o: 2 cycles (IDLE→ACCEPT, ACCEPT→WRITE) with valid already high.
- N-word load with continuous valid: done_o occurs 5N+1 cycles after the start_i edge.
- Reset mid-load: immediate return to IDLE with all outputs at reset values; memory contents are undefined beyond what was already written.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds output checksum_o (32 bits): the mod-2^32 sum of all words accepted since the last accepted start_i.
  - Cleared to 0 on reset and on accepted start.
  - Valid when done_o pulses.
- Not defined: the port and adder are absent; all other behaviour is identical.

## Structure
- Package dptr_pkg holds:
  - the loader state enum (IDLE/ACCEPT/WRITE/DONE)
  - BYTES_PER_WORD=4
  - the default MEM_BYTES=1024, shared with the instruction memory.
- One sub-module: imem_byte_serializer.
  - Takes a 32-bit word and a load strobe.
  - Emits four big-endian bytes with a 2-bit index and a last flag.
  - The top level owns the FSM, counters, validation and address generation.

## Test plan
- base=0x10, count=2, words 0xDEADBEEF then 0x00112233 with valid held high:
  - byte writes to 0x10..0x17 = DE AD BE EF 00 11 22 33
  - done_o at cycle 11 after start
  - words_written_o=2, error_o=0.
- base=0x02, count=1 → no mem_we_o, done_o one pulse, error_o=1. A following good start clears error_o.
- base=0x3FC, count=2 (end 0x404 > 1024) → rejected with error_o=1. base=0x3FC, count=1 → accepted, writes 0x3FC..0x3FF.
- count=3, abort_i asserted during the second word's idx 1 → writes stop the next cycle, error_o=1, words_written_o=1, no done_o.
- Word valid gapped (valid low for 3 cycles in ACCEPT) → word_ready_o stays high, no writes until valid, byte order unchanged.
- With IMEM_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 → checksum_o=0x00000001 at done_o.
